irq_encoder: RTL and testbench



---
 rtl/irq_encoder_pkg.sv | 19 +
 rtl/irq_encoder_prio_enc_comb.sv | 23 ++
 rtl/irq_encoder.sv | 103 ++++++++++
 tb/tb_irq_encoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_encoder_pkg.sv
// Shared types and helpers for the sticky-pending interrupt priority encoder.
package irq_encoder_pkg;

    localparam int unsigned DefN     = 4;
    localparam int unsigned MaxLines = 64;
    localparam int unsigned MaxCodeW = $clog2(MaxLines);

    typedef enum logic {
        StIdle  = 1'b0,
        StValid = 1'b1
    } state_t;

    // Callers truncate the result to their own line count.
    function automatic logic [MaxLines-1:0] onehot_of(input logic [MaxCodeW-1:0] code);
        onehot_of       = '0;
        onehot_of[code] = 1'b1;
    endfunction

endpackage

// File: rtl/irq_encoder_prio_enc_comb.sv
// Combinational priority encoder: the lowest set index of vec wins.
module prio_enc_comb #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan high to low so the last hit, the lowest index, takes effect.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_encoder.sv
// Captures request rising edges into sticky pending bits and presents the
// highest-priority unmasked one as a binary code under a valid/ack handshake.
module irq_encoder
    import irq_encoder_pkg::*;
#(
    parameter int unsigned N = DefN,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] mask_i,
    input  logic         ack_i,
    input  logic         err_clr_i,
    output logic [W-1:0] code_o,
    output logic         valid_o,
    output logic [N-1:0] pending_o,
    output logic         err_o
);

    logic [N-1:0] req_q;
    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;
    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic [N-1:0] eligible;
    logic [N-1:0] overrun;
    logic         err_q;
    logic         err_d;
    logic         ack_fire;
    state_t       state_q;
    logic [W-1:0] code_q;
    logic         valid_q;
    logic [W-1:0] prio_idx;
    logic         prio_any;

    assign rise     = req_i & ~req_q;
    assign ack_fire = (state_q == StValid) && ack_i;
    assign clr      = ack_fire ? N'(onehot_of(MaxCodeW'(code_q))) : '0;
    assign eligible = pending_q & ~mask_i;

    // A new rise on a bit being acknowledged in the same cycle is a fresh event,
    // not an overrun, so it re-pends without flagging an error.
    assign overrun   = rise & pending_q & ~clr;
    assign pending_d = (pending_q & ~clr) | rise;
    assign err_d     = (err_q & ~err_clr_i) | (|overrun);

    prio_enc_comb #(
        .N (N),
        .W (W)
    ) u_prio (
        .vec (eligible),
        .idx (prio_idx),
        .any (prio_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            req_q     <= req_i;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    // Code and valid are latched once and held until ack, whatever mask does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (prio_any) begin
                        code_q  <= prio_idx;
                        valid_q <= 1'b1;
                        state_q <= StValid;
                    end
                end
                StValid: begin
                    if (ack_i) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign code_o    = code_q;
    assign valid_o   = valid_q;
    assign pending_o = pending_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_irq_encoder.sv
// Directed bench for irq_encoder (N=4): expected codes are queued at stimulus
// time and popped when the encoder presents a valid code.
module tb_irq_encoder;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_i;
    logic [N-1:0] mask_i;
    logic         ack_i;
    logic         err_clr_i;
    logic [W-1:0] code_o;
    logic         valid_o;
    logic [N-1:0] pending_o;
    logic         err_o;

    int checks   = 0;
    int failures = 0;
    int unsigned sb[$];

    irq_encoder #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .mask_i    (mask_i),
        .ack_i     (ack_i),
        .err_clr_i (err_clr_i),
        .code_o    (code_o),
        .valid_o   (valid_o),
        .pending_o (pending_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a presentation, then compare against the scoreboard head.
    task automatic present(input string tag);
        int n = 0;
        int unsigned exp;
        while (valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(valid_o), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: observed code %0h with no expected code queued", tag, code_o);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_code"}, 32'(code_o), exp);
        end
    endtask

    task automatic do_ack();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    initial begin
        int extra;
        rst = 1'b1; req_i = '0; mask_i = '0; ack_i = 1'b0; err_clr_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_code", 32'(code_o), 32'd0);
        chk("rst_pending", 32'(pending_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);

        // Single pulse on bit 2: pending at E1, valid at E2.
        sb.push_back(2);
        req_i = 4'b0100;
        tick();
        req_i = '0;
        chk("t2_pend_e1", 32'(pending_o), 32'h4);
        chk("t2_valid_e1", 32'(valid_o), 32'd0);
        tick();
        chk("t2_valid_e2", 32'(valid_o), 32'd1);
        present("t2");
        do_ack();
        chk("t2_pend_ack", 32'(pending_o), 32'd0);
        chk("t2_valid_ack", 32'(valid_o), 32'd0);

        // Two simultaneous events: lowest index first, one idle cycle between.
        sb.push_back(1);
        sb.push_back(3);
        req_i = 4'b1010;
        tick();
        req_i = '0;
        present("t3a");
        do_ack();
        chk("t3_gap", 32'(valid_o), 32'd0);
        tick();
        chk("t3_next_e", 32'(valid_o), 32'd1);
        present("t3b");
        do_ack();
        chk("t3_pend", 32'(pending_o), 32'd0);
        tick();
        chk("t3_idle", 32'(valid_o), 32'd0);

        // Masked bit stays pending and becomes eligible once unmasked.
        mask_i = 4'b0001;
        sb.push_back(1);
        req_i = 4'b0011;
        tick();
        req_i = '0;
        present("t4a");
        do_ack();
        chk("t4_valid_masked", 32'(valid_o), 32'd0);
        chk("t4_pend_masked", 32'(pending_o), 32'h1);
        tick(); tick();
        chk("t4_still_idle", 32'(valid_o), 32'd0);
        mask_i = '0;
        sb.push_back(0);
        present("t4b");
        do_ack();
        chk("t4_pend_clear", 32'(pending_o), 32'd0);

        // Second event on a still-pending bit is an overrun.
        sb.push_back(2);
        req_i = 4'b0100;
        tick();
        req_i = '0;
        tick();
        chk("t5_err_before", 32'(err_o), 32'd0);
        req_i = 4'b0100;
        tick();
        req_i = '0;
        chk("t5_err_set", 32'(err_o), 32'd1);
        tick(); tick();
        chk("t5_err_sticky", 32'(err_o), 32'd1);
        chk("t5_pend", 32'(pending_o), 32'h4);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("t5_err_clr", 32'(err_o), 32'd0);
        present("t5");
        do_ack();

        // A held level is a single event.
        sb.push_back(3);
        req_i = 4'b1000;
        present("t6a");
        do_ack();
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (valid_o === 1'b1) extra++;
            tick();
        end
        chk("t6_no_repeat", 32'(extra), 32'd0);
        chk("t6_pend", 32'(pending_o), 32'd0);
        req_i = '0;
        tick();
        sb.push_back(3);
        req_i = 4'b1000;
        tick();
        req_i = '0;
        present("t6b");
        do_ack();

        // Ack and a new rise on the same bit in one cycle: set wins, no overrun.
        sb.push_back(2);
        req_i = 4'b0100;
        tick();
        req_i = '0;
        present("t7a");
        ack_i = 1'b1;
        req_i = 4'b0100;
        tick();
        ack_i = 1'b0;
        req_i = '0;
        chk("t7_pend", 32'(pending_o), 32'h4);
        chk("t7_err", 32'(err_o), 32'd0);
        chk("t7_gap", 32'(valid_o), 32'd0);
        sb.push_back(2);
        tick();
        chk("t7_re_e", 32'(valid_o), 32'd1);
        present("t7b");
        do_ack();

        // Asynchronous reset in the middle of a handshake with err set.
        req_i = 4'b0110;
        tick();
        req_i = '0;
        tick();
        req_i = 4'b0010;
        tick();
        req_i = '0;
        chk("t1_pre_valid", 32'(valid_o), 32'd1);
        chk("t1_pre_code", 32'(code_o), 32'd1);
        chk("t1_pre_pend", 32'(pending_o), 32'h6);
        chk("t1_pre_err", 32'(err_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_valid", 32'(valid_o), 32'd0);
        chk("t1_code", 32'(code_o), 32'd0);
        chk("t1_pend", 32'(pending_o), 32'd0);
        chk("t1_err", 32'(err_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
